// File: rtl/axi_lite_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to strobed register port bridge.
// Holds the channel FSM encodings, the fixed OKAY response and the word-address offset helper.
package axi_lite_reg_bridge_pkg;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_ISSUE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_CAPTURE,
    R_RESP
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Number of byte-offset bits dropped to form a register word address.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that turns register transactions into single-cycle wen/ren strobes.
// Write and read channels run as independent FSMs, each with one transaction outstanding.
module axi_lite_reg_bridge
  import axi_lite_reg_bridge_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 13,
  parameter int OPT_MEM_ADDR_BITS  = 10
) (
  input  logic                              axi_mm_clk,
  input  logic                              rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic                              wen,
  output logic [OPT_MEM_ADDR_BITS:0]        waddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb,
  output logic                              ren,
  output logic [OPT_MEM_ADDR_BITS:0]        raddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata
);

  localparam int ADDR_LSB = addr_lsb(C_S_AXI_DATA_WIDTH);
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int WORD_W   = OPT_MEM_ADDR_BITS + 1;

  wr_state_t                   wr_state;
  rd_state_t                   rd_state;
  logic [WORD_W-1:0]           aw_word;
  logic [WORD_W-1:0]           ar_word;
  logic [WORD_W-1:0]           aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]           w_strb_q;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        ar_hs;
  logic                        unused_inputs;

  assign aw_word = s_axi_awaddr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign ar_word = s_axi_araddr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign ar_hs   = s_axi_arvalid & s_axi_arready;

  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  // The port registers (waddr/wdata/wstrb) only change on the cycle wen is raised,
  // so a beat arriving early is parked in the *_q holding registers first.
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      wr_state      <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      wen           <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      wstrb         <= '0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      wen <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
          if (aw_hs && w_hs) begin
            waddr         <= aw_word;
            wdata         <= s_axi_wdata;
            wstrb         <= s_axi_wstrb;
            wen           <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            wr_state      <= W_ISSUE;
          end else if (aw_hs) begin
            aw_addr_q     <= aw_word;
            s_axi_awready <= 1'b0;
            wr_state      <= W_WAIT_W;
          end else if (w_hs) begin
            w_data_q      <= s_axi_wdata;
            w_strb_q      <= s_axi_wstrb;
            s_axi_wready  <= 1'b0;
            wr_state      <= W_WAIT_AW;
          end
        end
        W_WAIT_W: begin
          if (w_hs) begin
            waddr        <= aw_addr_q;
            wdata        <= s_axi_wdata;
            wstrb        <= s_axi_wstrb;
            wen          <= 1'b1;
            s_axi_wready <= 1'b0;
            wr_state     <= W_ISSUE;
          end
        end
        W_WAIT_AW: begin
          if (aw_hs) begin
            waddr         <= aw_word;
            wdata         <= w_data_q;
            wstrb         <= w_strb_q;
            wen           <= 1'b1;
            s_axi_awready <= 1'b0;
            wr_state      <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          s_axi_bvalid <= 1'b1;
          wr_state     <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // The register block samples ren on one edge and presents rdata after it,
  // hence the extra capture state between the strobe and the R response.
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      ren           <= 1'b0;
      raddr         <= '0;
    end else begin
      ren <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_hs) begin
            raddr         <= ar_word;
            ren           <= 1'b1;
            s_axi_arready <= 1'b0;
            rd_state      <= R_ISSUE;
          end
        end
        R_ISSUE: rd_state <= R_CAPTURE;
        R_CAPTURE: begin
          s_axi_rdata  <= rdata;
          s_axi_rvalid <= 1'b1;
          rd_state     <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
